imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 16, width of the illegal-instruction counter; legal range 4 to 32.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  block accepts an instruction this cycle.
REQ-007 in_inst  input  32  RV32/RV64 base instruction word.
REQ-008 out_valid  output  1  decoded result valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_imm  output  XLEN  sign-extended immediate.
REQ-011 out_fmt  output  3  format code: 0 = none, 1 = I, 2 = S, 3 = B, 4 = U, 5 = J.
REQ-012 out_illegal  output  1  opcode is not recognised.
REQ-013 illegal_cnt  output  CNT_W  saturating count of illegal instructions delivered downstream.

Function
REQ-014 Input transfer occurs when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-015 Latency is exactly 1 cycle: an instruction accepted at edge N is presented with out_valid = 1 after edge N.
REQ-016 I-format covers opcodes 0010011, 0000011, 1100111 and 0011011 (the last only when XLEN = 64); imm = sext(inst[31:20]).
REQ-017 S-format covers opcode 0100011; imm = sext({inst[31:25], inst[11:7]}).
REQ-018 B-format covers opcode 1100011; imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
REQ-019 U-format covers opcodes 0110111 and 0010111; imm = sext({inst[31:12], 12'b0}).
REQ-020 J-format covers opcode 1101111; imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
REQ-021 Opcodes 0110011, 0111011, 0001111 and 1110011 give out_fmt = 0, imm = 0 and out_illegal = 0.
REQ-022 Any other opcode gives out_fmt = 0, imm = 0 and out_illegal = 1.
REQ-023 Sign extension always replicates inst[31] up to bit XLEN-1.
REQ-024 illegal_cnt increments by 1 on each output transfer with out_illegal = 1 and holds at 2^CNT_W-1 once reached.
REQ-025 Results leave in acceptance order; no result is dropped or duplicated.
REQ-026 While out_valid = 1 and out_ready = 0, out_imm, out_fmt and out_illegal hold stable.
REQ-027 With the buffer empty, simultaneous input and output transfers in the same cycle are both honoured.

Reset
REQ-028 While reset = 1: out_valid = 0, out_imm = 0, out_fmt = 0, out_illegal = 0, illegal_cnt = 0, and all buffered entries are discarded.
REQ-029 in_ready = 0 while reset = 1 and becomes 1 in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-stream clears state immediately, without waiting for a clock edge; no pre-reset result appears afterwards.

Configuration
REQ-031 Macro IMM_GEN_PIPE_SKID_EN selects the buffering scheme.
REQ-032 With IMM_GEN_PIPE_SKID_EN defined: a 2-entry skid buffer is used; in_ready is driven directly from a register and is 0 only when both entries are full; in_ready has no combinational path from out_ready; full throughput is sustained under intermittent backpressure.
REQ-033 Without IMM_GEN_PIPE_SKID_EN: a single output register is used and in_ready = !out_valid || out_ready (combinational).
REQ-034 REQ-014 through REQ-030 hold in both builds.

Verification
REQ-035 in_inst 0xFFF00093 (addi x1,x0,-1), XLEN = 32 -> next cycle out_imm 0xFFFFFFFF, out_fmt 1; with XLEN = 64 -> 0xFFFFFFFFFFFFFFFF.
REQ-036 in_inst 0xFE112E23 (sw x1,-4(x2)) -> out_imm 0xFFFFFFFC, out_fmt 2; in_inst 0x123450B7 (lui) -> out_imm 0x12345000, out_fmt 4.
REQ-037 in_inst 0x004000EF (jal x1,+4) -> out_imm 0x00000004, out_fmt 5, out_illegal 0.
REQ-038 Three back-to-back instructions with out_ready low for 4 cycles -> skid build: in_ready falls after 2 accepts; all 3 results emerge in order with outputs stable while stalled; non-skid build: in_ready falls after 1 accept.
REQ-039 0x00000000 sent 3 times with CNT_W = 4 and illegal_cnt preloaded to 14 by prior traffic -> out_illegal 1, imm 0, illegal_cnt reads 15, 15, 15.
REQ-040 reset pulsed while 2 results are buffered -> out_valid 0 immediately; illegal_cnt 0; after reset, the first new input is the first output.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: RV32/RV64 immediate generator with a valid/ready stage.
// Decodes the opcode of each accepted instruction into a format code, a
// sign-extended immediate and an illegal flag, presented one cycle later.
// Also keeps a saturating count of illegal instructions delivered downstream.
//
// Build option: define IMM_GEN_PIPE_SKID_EN to use a 2-entry skid buffer with
// a registered in_ready. Without it, a single output register is used and
// in_ready is combinational.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } res_t;

  logic [6:0]  w_op;
  logic [31:0] w_imm32;
  res_t        w_dec;
  logic        w_in_xfer;
  logic        w_out_xfer;

  res_t             r_out;
  logic             r_out_vld;
  logic [CNT_W-1:0] r_ill_cnt;

  assign w_op = in_inst[6:0];

  // Opcode decode; the immediate is built at 32 bits, then widened by
  // replicating its top bit (which is inst[31] for every format that has one).
  always_comb begin
    w_imm32   = '0;
    w_dec     = '0;
    case (w_op)
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_dec.fmt = FMT_I;
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_IMM32: begin
        if (RV64) begin
          w_dec.fmt = FMT_I;
          w_imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        end else begin
          w_dec.ill = 1'b1;
        end
      end
      OP_STORE: begin
        w_dec.fmt = FMT_S;
        w_imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        w_dec.fmt = FMT_B;
        w_imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_dec.fmt = FMT_U;
        w_imm32   = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        w_dec.fmt = FMT_J;
        w_imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                     in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_REG, OP_REG32, OP_FENCE, OP_SYSTEM: begin
        w_dec.fmt = FMT_NONE;
      end
      default: begin
        w_dec.ill = 1'b1;
      end
    endcase
    w_dec.imm       = {XLEN{w_imm32[31]}};
    w_dec.imm[31:0] = w_imm32;
  end

  assign w_out_xfer = r_out_vld && out_ready;

`ifdef IMM_GEN_PIPE_SKID_EN
  res_t r_sk;
  logic r_sk_vld;
  logic r_in_rdy;
  logic w_sk_vld_nxt;

  assign in_ready  = r_in_rdy;
  assign w_in_xfer = in_valid && r_in_rdy;

  // Skid slot is occupied next cycle if the head is stalled and either the
  // slot was already full or a new entry just arrived behind the head.
  always_comb begin
    w_sk_vld_nxt = 1'b0;
    if (r_out_vld && !out_ready) w_sk_vld_nxt = r_sk_vld || w_in_xfer;
    else                         w_sk_vld_nxt = r_sk_vld && w_in_xfer;
  end

  // Head register refills from the skid slot first so order is preserved;
  // in_ready is registered and drops only when both slots will be full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
      r_sk      <= '0;
      r_sk_vld  <= 1'b0;
      r_in_rdy  <= 1'b0;
    end else begin
      if (!r_out_vld || out_ready) begin
        if (r_sk_vld) begin
          r_out     <= r_sk;
          r_out_vld <= 1'b1;
          if (w_in_xfer) r_sk <= w_dec;
        end else begin
          r_out_vld <= w_in_xfer;
          if (w_in_xfer) r_out <= w_dec;
        end
      end else if (w_in_xfer) begin
        r_sk <= w_dec;
      end
      r_sk_vld <= w_sk_vld_nxt;
      r_in_rdy <= !w_sk_vld_nxt;
    end
  end
`else
  // Accept whenever the single output register is empty or draining;
  // reset forces it low without waiting for a clock.
  assign in_ready  = !reset && (!r_out_vld || out_ready);
  assign w_in_xfer = in_valid && in_ready;

  // Single output register: load on accept, empty on delivery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else if (w_in_xfer) begin
      r_out     <= w_dec;
      r_out_vld <= 1'b1;
    end else if (w_out_xfer) begin
      r_out_vld <= 1'b0;
    end
  end
`endif

  // Count illegal results as they leave, holding at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ill_cnt <= '0;
    end else if (w_out_xfer && r_out.ill && (r_ill_cnt != {CNT_W{1'b1}})) begin
      r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign out_valid   = r_out_vld;
  assign out_imm     = r_out.imm;
  assign out_fmt     = r_out.fmt;
  assign out_illegal = r_out.ill;
  assign illegal_cnt = r_ill_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe (XLEN=64, CNT_W=4): random traffic against a
// queue-based reference model plus directed vectors, stall, saturation and
// mid-stream reset scenarios. Follows IMM_GEN_PIPE_SKID_EN like the design.
module tb_imm_gen_pipe;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef IMM_GEN_PIPE_SKID_EN
  localparam int STALL_ACC = 2;
`else
  localparam int STALL_ACC = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  imm_gen_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ent_t;

  ent_t q[$];
  int   mcnt;
  int   n_chk = 0;
  int   n_err = 0;
  logic last_acc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the format rules, using signed 32-bit arithmetic.
  function automatic ent_t ref_dec(input logic [31:0] x);
    ent_t e;
    int   s, hi, v;
    s = $signed(x);
    v = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    case (x[6:0])
      7'h13, 7'h03, 7'h67: begin e.fmt = 3'd1; v = s >>> 20; end
      7'h1B: begin
        if (XLEN == 64) begin e.fmt = 3'd1; v = s >>> 20; end
        else e.ill = 1'b1;
      end
      7'h23: begin
        e.fmt = 3'd2; hi = s >>> 20;
        v = (hi & ~32'h1F) | ((x >> 7) & 32'h1F);
      end
      7'h63: begin
        e.fmt = 3'd3; hi = s >>> 19;
        v = (hi & ~32'hFFF) | (((x >> 7) & 32'h1) << 11)
          | (((x >> 25) & 32'h3F) << 5) | (((x >> 8) & 32'hF) << 1);
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; v = s & 32'hFFFFF000; end
      7'h6F: begin
        e.fmt = 3'd5; hi = s >>> 11;
        v = (hi & ~32'hFFFFF) | (x & 32'hFF000)
          | (((x >> 20) & 32'h1) << 11) | (((x >> 21) & 32'h3FF) << 1);
      end
      7'h33, 7'h3B, 7'h0F, 7'h73: e.fmt = 3'd0;
      default: e.ill = 1'b1;
    endcase
    e.imm = 64'(longint'(v));
    return e;
  endfunction

  // One clock: drive at negedge, check against model, advance model.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic ordy);
    logic exp_rdy;
    @(negedge clk);
    in_valid = v; in_inst = inst; out_ready = ordy;
    #1;
    chk("vld", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("imm", out_imm, q[0].imm);
      chk("fmt", out_fmt, q[0].fmt);
      chk("ill", out_illegal, q[0].ill);
    end
    chk("cnt", illegal_cnt, mcnt);
`ifdef IMM_GEN_PIPE_SKID_EN
    exp_rdy = q.size() < 2;
`else
    exp_rdy = (q.size() == 0) || ordy;
`endif
    chk("rdy", in_ready, exp_rdy);
    last_acc = v && exp_rdy;
    if (q.size() > 0 && ordy) begin
      if (q[0].ill && mcnt < CMAX) mcnt++;
      void'(q.pop_front());
    end
    if (last_acc) q.push_back(ref_dec(inst));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  // Send one instruction into an empty pipe and check literal results.
  task automatic dir_chk(input logic [31:0] inst, input logic [63:0] imm,
                         input logic [2:0] fmt, input logic ill);
    cycle(1'b1, inst, 1'b0);
    chk("d_vld", out_valid, 1);
    chk("d_imm", out_imm, imm);
    chk("d_fmt", out_fmt, fmt);
    chk("d_ill", out_illegal, ill);
    cycle(1'b0, 32'h0, 1'b1);
  endtask

  task automatic drain();
    repeat (3) cycle(1'b0, 32'h0, 1'b1);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_vld", out_valid, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_fmt", out_fmt, 0);
    chk("rst_ill", out_illegal, 0);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_rdy", in_ready, 0);
    q.delete(); mcnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rdy", in_ready, 1);
    chk("post_vld", out_valid, 0);
  endtask

  logic [6:0]  ops [15] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37,
                            7'h17, 7'h6F, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h00, 7'h7F};
  logic [31:0] sv  [3]  = '{32'h00A00513, 32'hFE112E23, 32'h00000000};

  initial begin
    logic [31:0] r;
    int          idx, pick;
    reset = 1'b0; in_valid = 1'b0; in_inst = '0; out_ready = 1'b0;
    mcnt = 0; last_acc = 1'b0;
    #2;
    do_reset();

    // Directed vectors
    dir_chk(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    dir_chk(32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0);
    dir_chk(32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    dir_chk(32'h004000EF, 64'h0000_0000_0000_0004, 3'd5, 1'b0);
    dir_chk(32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0);
    dir_chk(32'hFFF0001B, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
    dir_chk(32'hFFF00033, 64'h0, 3'd0, 1'b0);

    // Saturating counter: 14 illegal, then 3 more reading 15
    do_reset();
    repeat (14) dir_chk(32'h00000000, 64'h0, 3'd0, 1'b1);
    chk("cnt14", illegal_cnt, 14);
    repeat (3) begin
      dir_chk(32'h00000000, 64'h0, 3'd0, 1'b1);
      chk("cnt_sat", illegal_cnt, 15);
    end

    // Back-to-back with 4 stalled cycles
    idx = 0;
    repeat (4) begin
      cycle(idx < 3, sv[idx < 3 ? idx : 0], 1'b0);
      if (last_acc) idx++;
    end
    chk("stall_acc", idx, STALL_ACC);
    for (int i = 0; i < 20 && (idx < 3 || q.size() > 0); i++) begin
      cycle(idx < 3, sv[idx < 3 ? idx : 0], 1'b1);
      if (last_acc) idx++;
    end

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom;
      pick = $urandom_range(0, 15);
      if (pick < 15) r[6:0] = ops[pick];
      cycle(($urandom % 4) != 0, r, ($urandom % 3) != 0);
    end
    drain();

    // Reset while results are buffered
    cycle(1'b1, 32'h00100093, 1'b0);
    cycle(1'b1, 32'h00200093, 1'b0);
    chk("pre_rst_vld", out_valid, 1);
    do_reset();
    dir_chk(32'h123450B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
